// File: rtl/sar_avg_sequencer.sv
// rtl/sar_avg_sequencer.sv - SAR conversion sequencer with power-of-two averaging
// Issues periodic soc pulses, captures eoc results and presents the truncated average.
module sar_avg_sequencer #(
  parameter int DATA_W   = 10,
  parameter int AVG_LOG2 = 2,
  parameter int PERIOD_W = 16,
  parameter int TIMEOUT  = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [PERIOD_W-1:0] period,
  output logic                soc,
  input  logic                eoc,
  input  logic [DATA_W-1:0]   adc_data,
  output logic [DATA_W-1:0]   avg_data,
  output logic                avg_valid,
  input  logic                avg_ready,
  output logic                overrun,
  output logic                err_timeout,
  output logic                busy
);

  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam int TW    = (PERIOD_W > TO_W) ? PERIOD_W : TO_W;
  localparam int ACC_W = DATA_W + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

  typedef enum logic [2:0] {IDLE, TRIG, WAIT_LOW, WAIT_EOC, HOLD} state_t;

  state_t            state, state_next;
  logic [TW-1:0]     timer;
  logic [TW-1:0]     period_m1;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  sum;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] result;
  logic              timed_out;
  logic              hold_done;
  logic              capture;
  logic              last;

  always_comb begin
    period_m1 = (period == '0) ? '0 : TW'(period) - TW'(1);
    hold_done = timer >= period_m1;
    timed_out = ((state == WAIT_LOW) || (state == WAIT_EOC)) && (timer >= TW'(TIMEOUT));
    capture   = (state == WAIT_EOC) && eoc && !timed_out;
    sum       = acc + ACC_W'(adc_data);
    last      = count == CNT_LAST;
    result    = DATA_W'(sum >> AVG_LOG2);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (en) state_next = TRIG;
      TRIG:     state_next = WAIT_LOW;
      WAIT_LOW: begin
        if (timed_out)  state_next = HOLD;
        else if (!eoc)  state_next = WAIT_EOC;
      end
      WAIT_EOC: if (timed_out || eoc) state_next = HOLD;
      HOLD:     if (hold_done) state_next = en ? TRIG : IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    soc  = (state == TRIG) && !rst;
    busy = state != IDLE;
  end

  // One shared timer: counts cycles since TRIG for both the period and the eoc timeout.
  always_ff @(posedge clk) begin
    if (rst || state_next == TRIG) timer <= '0;
    else if (timer != '1)          timer <= timer + TW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst || state == IDLE || (state == HOLD && hold_done && !en)) begin
      acc   <= '0;
      count <= '0;
    end else if (capture) begin
      if (last) begin
        acc   <= '0;
        count <= '0;
      end else begin
        acc   <= sum;
        count <= count + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      avg_data    <= '0;
      avg_valid   <= 1'b0;
      overrun     <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      if (capture && last) begin
        if (!avg_valid || avg_ready) begin
          avg_data  <= result;
          avg_valid <= 1'b1;
        end else begin
          overrun   <= 1'b1;
        end
      end else if (avg_valid && avg_ready) begin
        avg_valid <= 1'b0;
      end
      if (timed_out) err_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sar_avg_sequencer.sv
// tb/tb_sar_avg_sequencer.sv - directed self-checking bench for sar_avg_sequencer
// A behavioural SAR answers each soc: eoc low at T+1, high with data from T+13.
module tb_sar_avg_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [15:0] period = 16'd20;
  logic        soc;
  logic        eoc = 1'b0;
  logic [9:0]  adc_data = '0;
  logic [9:0]  avg_data;
  logic        avg_valid;
  logic        avg_ready = 1'b0;
  logic        overrun;
  logic        err_timeout;
  logic        busy;

  sar_avg_sequencer #(
    .DATA_W(10), .AVG_LOG2(2), .PERIOD_W(16), .TIMEOUT(64)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .period(period), .soc(soc), .eoc(eoc),
    .adc_data(adc_data), .avg_data(avg_data), .avg_valid(avg_valid),
    .avg_ready(avg_ready), .overrun(overrun), .err_timeout(err_timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vals [0:15];
  int sidx = 0;
  int k = 0;
  bit dead = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      k    <= 0;
      eoc  <= 1'b0;
      sidx <= 0;
    end else if (soc) begin
      k   <= 1;
      eoc <= 1'b0;
    end else if (k != 0) begin
      if (k == 12) begin
        k <= 0;
        if (!dead) begin
          eoc      <= 1'b1;
          adc_data <= 10'(vals[sidx & 15]);
          sidx     <= sidx + 1;
        end
      end else begin
        k <= k + 1;
      end
    end
  end

  int soc_cyc [0:511];
  int n_soc = 0;
  int v_cyc [0:63];
  int v_dat [0:63];
  int v_cnt = 0;
  bit prev_v = 1'b0;

  always @(negedge clk) begin
    if (soc) begin
      if (n_soc < 512) soc_cyc[n_soc] = cyc;
      n_soc++;
    end
    if (avg_valid && !prev_v) begin
      if (v_cnt < 64) begin
        v_cyc[v_cnt] = cyc;
        v_dat[v_cnt] = int'(avg_data);
      end
      v_cnt++;
    end
    prev_v = avg_valid;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic step_to(input int c);
    while (cyc < c) step(1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en  = 1'b0;
    step(3);
    rst = 1'b0;
    step(1);
  endtask

  task automatic wait_soc(input int target, input int budget, input string tag);
    int i = 0;
    while (n_soc < target && i < budget) begin
      step(1);
      i++;
    end
    chk(tag, int'(n_soc >= target), 1);
  endtask

  task automatic wait_valid(input int target, input int budget, input string tag);
    int i = 0;
    while (v_cnt < target && i < budget) begin
      step(1);
      i++;
    end
    chk(tag, int'(v_cnt >= target), 1);
  endtask

  task automatic set_vals(input int a, input int b, input int c, input int d,
                          input int e, input int f, input int g, input int h);
    vals[0] = a; vals[1] = b; vals[2] = c; vals[3] = d;
    vals[4] = e; vals[5] = f; vals[6] = g; vals[7] = h;
  endtask

  int s0, s1, v0, t, c, i;

  initial begin
    for (int j = 0; j < 16; j++) vals[j] = 0;

    // Reset state
    do_reset();
    chk("rst_soc", int'(soc), 0);
    chk("rst_valid", int'(avg_valid), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_err", int'(err_timeout), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_data", int'(avg_data), 0);

    // 100..103, period 20: average 406>>2 = 101
    set_vals(100, 101, 102, 103, 0, 0, 0, 0);
    period = 16'd20; avg_ready = 1'b1;
    s0 = n_soc; v0 = v_cnt;
    en = 1'b1;
    wait_valid(v0 + 1, 200, "t1_valid_timeout");
    chk("t1_data", v_dat[v0], 101);
    chk("t1_latency", v_cyc[v0] - soc_cyc[s0], 74);
    chk("t1_spacing", soc_cyc[s0+1] - soc_cyc[s0], 20);
    chk("t1_overrun", int'(overrun), 0);
    en = 1'b0;
    step(1);
    chk("t1_valid_drop", int'(avg_valid), 0);
    step(40);
    chk("t1_one_pulse", v_cnt - v0, 1);

    // period 5 clamps to 15-cycle spacing; capture 13 cycles after soc
    do_reset();
    set_vals(40, 41, 42, 43, 0, 0, 0, 0);
    period = 16'd5;
    s0 = n_soc; v0 = v_cnt;
    en = 1'b1;
    wait_valid(v0 + 1, 200, "t2_valid_timeout");
    chk("t2_spacing01", soc_cyc[s0+1] - soc_cyc[s0], 15);
    chk("t2_spacing23", soc_cyc[s0+3] - soc_cyc[s0+2], 15);
    chk("t2_latency", v_cyc[v0] - soc_cyc[s0], 59);
    chk("t2_capture", v_cyc[v0] - soc_cyc[s0+3], 14);
    chk("t2_data", v_dat[v0], 41);
    en = 1'b0;
    step(30);

    // Full-scale samples, period 0 treated as 1
    do_reset();
    set_vals(1023, 1023, 1023, 1023, 0, 0, 0, 0);
    period = 16'd0;
    s0 = n_soc; v0 = v_cnt;
    en = 1'b1;
    wait_valid(v0 + 1, 200, "t3_valid_timeout");
    chk("t3_data", v_dat[v0], 1023);
    chk("t3_spacing", soc_cyc[s0+1] - soc_cyc[s0], 15);
    en = 1'b0;
    step(30);

    // Backpressure: second average (60) dropped, 50 held
    do_reset();
    set_vals(50, 50, 50, 50, 60, 60, 60, 60);
    period = 16'd15; avg_ready = 1'b0;
    v0 = v_cnt;
    en = 1'b1;
    wait_valid(v0 + 1, 200, "t4_valid_timeout");
    chk("t4_first", v_dat[v0], 50);
    i = 0;
    while (!overrun && i < 150) begin
      step(1);
      i++;
    end
    en = 1'b0;
    chk("t4_overrun", int'(overrun), 1);
    chk("t4_held_data", int'(avg_data), 50);
    chk("t4_held_valid", int'(avg_valid), 1);
    avg_ready = 1'b1;
    step(1);
    chk("t4_valid_drop", int'(avg_valid), 0);
    step(40);

    // Missing eoc: timeout, then the next TRIG still fires
    do_reset();
    dead = 1'b1;
    period = 16'd20;
    s0 = n_soc;
    en = 1'b1;
    wait_soc(s0 + 1, 10, "t5_soc_timeout");
    t = soc_cyc[s0];
    step_to(t + 60);
    chk("t5_err_early", int'(err_timeout), 0);
    step_to(t + 70);
    chk("t5_err", int'(err_timeout), 1);
    wait_soc(s0 + 2, 100, "t5_resoc_timeout");
    chk("t5_resoc_gap", soc_cyc[s0+1] - t, 66);
    en = 1'b0;
    step(100);
    dead = 1'b0;

    // en dropped after two captures discards the partial sum
    do_reset();
    set_vals(20, 20, 8, 8, 8, 8, 0, 0);
    period = 16'd30; avg_ready = 1'b1;
    s0 = n_soc; v0 = v_cnt;
    en = 1'b1;
    wait_soc(s0 + 2, 80, "t6_soc_timeout");
    step_to(soc_cyc[s0+1] + 16);
    en = 1'b0;
    i = 0;
    while (busy && i < 50) begin
      step(1);
      i++;
    end
    chk("t6_idle", int'(busy), 0);
    chk("t6_no_valid", v_cnt - v0, 0);
    en = 1'b1;
    wait_valid(v0 + 1, 250, "t6_valid_timeout");
    chk("t6_data", v_dat[v0], 8);
    en = 1'b0;
    step(40);

    // Reset mid-conversion, restart via IDLE -> TRIG
    do_reset();
    set_vals(5, 5, 5, 5, 0, 0, 0, 0);
    period = 16'd20;
    s0 = n_soc;
    en = 1'b1;
    wait_soc(s0 + 1, 10, "t7_soc_timeout");
    t = soc_cyc[s0];
    step_to(t + 6);
    rst = 1'b1;
    step(1);
    chk("t7_busy", int'(busy), 0);
    chk("t7_soc", int'(soc), 0);
    chk("t7_valid", int'(avg_valid), 0);
    chk("t7_flags", int'({overrun, err_timeout}), 0);
    chk("t7_data", int'(avg_data), 0);
    chk("t7_no_extra_soc", n_soc - s0, 1);
    rst = 1'b0;
    c = cyc;
    s1 = n_soc;
    wait_soc(s1 + 1, 10, "t7_resoc_timeout");
    chk("t7_resoc_delay", soc_cyc[s1] - c, 1);
    en = 1'b0;
    step(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
